// File: rtl/bomb_pkg.sv
// bomb_pkg: shared slot encoding and grid constants for the bomb manager.
package bomb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } slot_state_t;
    localparam int NUM_SLOTS = 6;
    localparam int COORD_W = 6;
    localparam int GRID_MAX_X = 39;
    localparam int GRID_MAX_Y = 29;
    localparam logic [COORD_W-1:0] EMPTY_COORD = 6'd63;
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot holding state, coordinates and fuse counter.
module bomb_slot import bomb_pkg::*; #(
    parameter logic [11:0] FUSE_MS = 12'd3000,
    parameter logic [COORD_W-1:0] EMPTY = EMPTY_COORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_tick,
    input  logic               i_grant,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [1:0]         o_state,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);
    slot_state_t        r_state;
    logic [11:0]        r_fuse;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    // Coordinate registers double as the bus fields, so an idle slot holds EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_fuse  <= '0;
            r_x     <= EMPTY;
            r_y     <= EMPTY;
        end else begin
            case (r_state)
                IDLE: if (i_load) begin
                    r_state <= ARMED;
                    r_fuse  <= FUSE_MS;
                    r_x     <= i_x;
                    r_y     <= i_y;
                end
                ARMED: if (i_tick) begin
                    r_fuse <= r_fuse - 12'd1;
                    if (r_fuse == 12'd1) r_state <= PENDING;
                end
                PENDING: if (i_grant) begin
                    r_state <= IDLE;
                    r_x     <= EMPTY;
                    r_y     <= EMPTY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_x = r_x;
    assign o_y = r_y;
endmodule

// File: rtl/bomb_manager.sv
// bomb_manager: bomb placement, fuse tracking, explosion arbitration and
// the packed occupancy bus read by the player-movement logic.
module bomb_manager #(
    parameter int         FUSE_MS     = 3000,
    parameter int         MAX_BOMBS   = 6,
    parameter logic [5:0] EMPTY_COORD = bomb_pkg::EMPTY_COORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1ms,
    input  logic        place,
    input  logic [9:0]  man_x,
    input  logic [9:0]  man_y,
    output logic [1:36] bomb_x,
    output logic [1:36] bomb_y,
    output logic        explode,
    output logic [5:0]  explode_x,
    output logic [5:0]  explode_y,
    output logic        place_reject,
    output logic [2:0]  bomb_count
);
    import bomb_pkg::*;

    logic [1:0]         w_st [NUM_SLOTS];
    logic [COORD_W-1:0] w_sx [NUM_SLOTS];
    logic [COORD_W-1:0] w_sy [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_idle, w_busy, w_pend, w_match, w_grant, w_load;
    logic               w_rise, w_in_range, w_accept;
    logic [COORD_W-1:0] w_ex_x, w_ex_y;
    logic [2:0]         w_cnt;
    logic               r_place_low;
    logic               r_explode;
    logic [COORD_W-1:0] r_ex_x, r_ex_y;
    logic               r_reject;
    logic [2:0]         r_count;

    always_comb begin
        w_rise = place & r_place_low;
        w_in_range = (man_x <= 10'(GRID_MAX_X)) && (man_y <= 10'(GRID_MAX_Y));
        w_idle = '0;
        w_busy = '0;
        w_pend = '0;
        w_match = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_idle[k] = (w_st[k] == IDLE) && (k < MAX_BOMBS);
            w_busy[k] = (w_st[k] == ARMED) || (w_st[k] == PENDING);
            w_pend[k] = w_st[k] == PENDING;
            w_match[k] = w_busy[k] && (w_sx[k] == man_x[COORD_W-1:0]) && (w_sy[k] == man_y[COORD_W-1:0]);
        end
        w_grant = w_pend & (~w_pend + 6'd1);
        w_accept = w_rise && w_in_range && (|w_idle) && !(|w_match);
        w_load = w_accept ? (w_idle & (~w_idle + 6'd1)) : '0;
        w_ex_x = '0;
        w_ex_y = '0;
        w_cnt = {2'b0, w_accept};
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_ex_x = w_ex_x | (w_grant[k] ? w_sx[k] : '0);
            w_ex_y = w_ex_y | (w_grant[k] ? w_sy[k] : '0);
            w_cnt = w_cnt + {2'b0, w_busy[k] & ~w_grant[k]};
        end
    end

    // r_place_low means "previous sample was low"; clearing it on reset makes a
    // button held through reset look already pressed, so it cannot place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_place_low <= 1'b0;
            r_explode   <= 1'b0;
            r_ex_x      <= '0;
            r_ex_y      <= '0;
            r_reject    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_place_low <= ~place;
            r_explode   <= |w_grant;
            r_ex_x      <= w_ex_x;
            r_ex_y      <= w_ex_y;
            r_reject    <= w_rise & ~w_accept;
            r_count     <= w_cnt;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            bomb_slot #(
                .FUSE_MS(12'(FUSE_MS)),
                .EMPTY  (EMPTY_COORD)
            ) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_load[k]),
                .i_tick (tick_1ms),
                .i_grant(w_grant[k]),
                .i_x    (man_x[COORD_W-1:0]),
                .i_y    (man_y[COORD_W-1:0]),
                .o_state(w_st[k]),
                .o_x    (w_sx[k]),
                .o_y    (w_sy[k])
            );
            assign bomb_x[6*k+1 +: 6] = w_sx[k];
            assign bomb_y[6*k+1 +: 6] = w_sy[k];
        end
    endgenerate

    assign explode = r_explode;
    assign explode_x = r_ex_x;
    assign explode_y = r_ex_y;
    assign place_reject = r_reject;
    assign bomb_count = r_count;
endmodule
